// File: rtl/fir_pkg.sv
// Constants and state encoding shared by the FIR core, the sample feeder and its bench.
package fir_pkg;
   localparam int SAMPLE_W  = 16;
   localparam int FRAME_LEN = 64;
   localparam int WR_CNT_W  = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;
endpackage

// File: rtl/fir_sample_feeder.sv
// Frames a valid/ready sample stream into the FIR core's input FIFO, one
// FRAME_LEN burst per able2write high phase.
module fir_sample_feeder
   import fir_pkg::*;
#(
   parameter int SAMPLE_W  = fir_pkg::SAMPLE_W,
   parameter int FRAME_LEN = fir_pkg::FRAME_LEN,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                able2write,
   output logic [SAMPLE_W-1:0] data_in,
   output logic                in_write_ctrl,
   output logic                frame_done,
   output logic [CNT_W-1:0]    frame_count,
   output logic                proto_err
);
   localparam int WR_W = $clog2(FRAME_LEN);
   localparam logic [WR_W-1:0] LAST_WORD = WR_W'(FRAME_LEN - 1);

   feeder_state_t       r_state;
   logic [WR_W-1:0]     r_wr_cnt;
   logic [SAMPLE_W-1:0] r_data;
   logic                r_write;
   logic                r_frame_done;
   logic [CNT_W-1:0]    r_frame_count;
   logic                r_proto_err;
   logic                w_accept;

   // able2write gates acceptance directly so a premature drain stalls the
   // very cycle it is seen.
   assign s_ready  = (r_state == FILL) && able2write;
   assign w_accept = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_wr_cnt      <= '0;
         r_data        <= '0;
         r_write       <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         r_proto_err   <= 1'b0;
      end else begin
         r_write      <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_accept) begin
            r_data  <= s_data;
            r_write <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (able2write) begin
                  r_state  <= FILL;
                  r_wr_cnt <= '0;
               end
            end
            FILL: begin
               // The last-word transition wins over the drain check.
               if (w_accept) begin
                  if (r_wr_cnt == LAST_WORD) begin
                     r_state       <= DRAIN;
                     r_wr_cnt      <= '0;
                     r_frame_done  <= 1'b1;
                     r_frame_count <= r_frame_count + CNT_W'(1);
                  end else begin
                     r_wr_cnt <= r_wr_cnt + WR_W'(1);
                  end
               end else if (!able2write) begin
                  r_proto_err <= 1'b1;
               end
            end
            DRAIN: begin
               // Wait out the core's stale-high flag until it starts reading.
               if (!able2write) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign data_in       = r_data;
   assign in_write_ctrl = r_write;
   assign frame_done    = r_frame_done;
   assign frame_count   = r_frame_count;
   assign proto_err     = r_proto_err;
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: table of frame scenarios plus hand-written reset
// sequences; a narrow frame counter makes the wrap reachable in a short run.
module tb_fir_sample_feeder;
   localparam int SW    = 16;
   localparam int FL    = 64;
   localparam int CW    = 3;
   localparam int NVEC  = 9;

   typedef struct {
      int           gap;
      logic         alt;
      logic [SW-1:0] v0;
      logic [SW-1:0] v1;
      int           drop_at;
      int           drop_len;
      logic [CW-1:0] exp_cnt;
      logic         exp_proto;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          able2write;
   logic [SW-1:0] data_in;
   logic          in_write_ctrl;
   logic          frame_done;
   logic [CW-1:0] frame_count;
   logic          proto_err;

   fir_sample_feeder #(.SAMPLE_W(SW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .able2write   (able2write),
      .data_in      (data_in),
      .in_write_ctrl(in_write_ctrl),
      .frame_done   (frame_done),
      .frame_count  (frame_count),
      .proto_err    (proto_err)
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   int            accepted = 0;
   int            total_writes = 0;
   int            mon_wf = 0;
   logic [CW-1:0] mon_cnt = '0;
   logic [SW-1:0] sb[$];
   vec_t          vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Write-side monitor: pops the scoreboard on every FIFO write.
   always @(negedge clk) begin
      if (rst) begin
         mon_wf  = 0;
         mon_cnt = '0;
      end else if (in_write_ctrl) begin
         total_writes++;
         if (sb.size() == 0) begin
            chk("extra_write", 32'(data_in), 32'hDEAD_BEEF);
         end else begin
            chk("data_in", 32'(data_in), 32'(sb.pop_front()));
         end
         chk("frame_done_on_write", 32'(frame_done), 32'(mon_wf == FL - 1));
         if (mon_wf == FL - 1) begin
            mon_wf  = 0;
            mon_cnt = mon_cnt + CW'(1);
            chk("frame_count_at_done", 32'(frame_count), 32'(mon_cnt));
         end else begin
            mon_wf++;
         end
      end else begin
         chk("frame_done_no_write", 32'(frame_done), 32'd0);
      end
   end

   task automatic step(input logic v, input logic [SW-1:0] d, input logic a);
      s_valid    = v;
      s_data     = d;
      able2write = a;
      @(negedge clk);
      if (v && s_ready) begin
         sb.push_back(d);
         accepted++;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] sample_of(input vec_t t, input int idx);
      if (t.alt) return (idx % 2 == 0) ? t.v0 : t.v1;
      return t.v0 + SW'(idx);
   endfunction

   task automatic run_frame(input vec_t t, input string tag);
      int  k = 0;
      int  w0 = total_writes;
      int  snap;
      bit  dropped = 0;
      accepted = 0;
      while (accepted < FL && k < 3000) begin
         if (t.drop_len > 0 && !dropped && accepted == t.drop_at) begin
            snap = 0;
            for (int j = 0; j < t.drop_len; j++) begin
               step(1'b1, 16'hBAD0, 1'b0);
               chk({tag, "_ready_in_drop"}, 32'(s_ready), 32'd0);
               if (j == 0) snap = total_writes;
            end
            chk({tag, "_writes_in_drop"}, 32'(total_writes), 32'(snap));
            chk({tag, "_proto_err"}, 32'(proto_err), 32'd1);
            dropped = 1;
         end
         step((k % (t.gap + 1)) == 0, sample_of(t, accepted), 1'b1);
         k++;
      end
      chk({tag, "_accept_timeout"}, 32'(accepted), 32'(FL));
      // able2write stays high a few cycles past the last write: no new accepts.
      for (int j = 0; j < 3; j++) begin
         step(1'b1, 16'h5555, 1'b1);
         chk({tag, "_ready_stale_high"}, 32'(s_ready), 32'd0);
      end
      chk({tag, "_writes_per_frame"}, 32'(total_writes - w0), 32'(FL));
      chk({tag, "_frame_count"}, 32'(frame_count), 32'(t.exp_cnt));
      chk({tag, "_proto_sticky"}, 32'(proto_err), 32'(t.exp_proto));
      step(1'b0, '0, 1'b0);
      chk({tag, "_ready_low_phase"}, 32'(s_ready), 32'd0);
   endtask

   initial begin
      //            gap alt  v0        v1        drop  len cnt   proto
      vecs[0] = '{0, 1'b0, 16'h0001, 16'h0000, 0,  0, 3'd1, 1'b0};
      vecs[1] = '{2, 1'b1, 16'h8000, 16'h7FFF, 0,  0, 3'd2, 1'b0};
      vecs[2] = '{0, 1'b0, 16'h1000, 16'h0000, 20, 5, 3'd3, 1'b1};
      vecs[3] = '{0, 1'b1, 16'hFFFF, 16'h0000, 0,  0, 3'd4, 1'b1};
      vecs[4] = '{1, 1'b0, 16'hFFC0, 16'h0000, 0,  0, 3'd5, 1'b1};
      vecs[5] = '{0, 1'b1, 16'hA5A5, 16'h5A5A, 0,  0, 3'd6, 1'b1};
      vecs[6] = '{0, 1'b0, 16'h7FE0, 16'h0000, 0,  0, 3'd7, 1'b1};
      vecs[7] = '{0, 1'b1, 16'h0123, 16'hFEDC, 0,  0, 3'd0, 1'b1};
      vecs[8] = '{1, 1'b1, 16'h8001, 16'h7FFE, 0,  0, 3'd1, 1'b1};

      rst = 1'b1; s_valid = 1'b1; s_data = 16'h1234; able2write = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_write", 32'(in_write_ctrl), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
      rst = 1'b0; s_valid = 1'b0; able2write = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(s_ready), 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         run_frame(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of a frame, after word 30 has been accepted.
      accepted = 0;
      for (int k = 0; k < 200 && accepted < 30; k++) begin
         step(1'b1, 16'h3000 + SW'(accepted), 1'b1);
      end
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      chk("midrst_write", 32'(in_write_ctrl), 32'd0);
      chk("midrst_data_in", 32'(data_in), 32'd0);
      chk("midrst_count", 32'(frame_count), 32'd0);
      chk("midrst_proto", 32'(proto_err), 32'd0);
      chk("midrst_ready", 32'(s_ready), 32'd0);
      run_frame('{0, 1'b0, 16'h4000, 16'h0000, 0, 0, 3'd1, 1'b0}, "after_rst");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
